tanh_share_arb: RTL and testbench

//   Shares one tanhPWL activation unit between N_REQ requesters (e.g. LSTM gate lanes).

---
 rtl/tanh_share_arb.sv | 114 +++++++++++
 tb/tb_tanh_share_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tanh_share_arb.sv
// Round-robin sharing of one tanhPWL unit between N_REQ requesters.
// A LAT-deep tag pipe routes each unit result back to its owner's result register.
module tanh_share_arb #(
    parameter int N_REQ = 4,
    parameter int DW    = 16,
    parameter int LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_x,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [N_REQ*DW-1:0] rsp_y,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [DW-1:0]       tanh_x,
    input  logic [DW-1:0]       tanh_y,
    output logic                busy
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] slot_busy;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] rsp_hs;
    logic [N_REQ-1:0] land;
    logic [IDW:0]     pick;
    logic             any_grant;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   ptr_nxt;

    logic [LAT-1:0]   tag_vld_p;
    logic [IDW-1:0]   tag_id_p [LAT];

    // First eligible lane at or above start, wrapping; MSB of the result flags a find.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] elig,
                                             input logic [IDW-1:0]   start);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(start) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!res[IDW] && elig[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign rsp_hs = rsp_valid & rsp_ready;

    // Eligibility is forced to zero while reset is held so nothing is granted.
    assign eligible  = rst ? (req_valid & (~slot_busy | rsp_hs)) : '0;
    assign pick      = rr_pick(eligible, ptr);
    assign any_grant = pick[IDW];
    assign grant_id  = pick[IDW-1:0];
    assign ptr_nxt   = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);

    always_comb begin
        grant = '0;
        if (any_grant) grant[grant_id] = 1'b1;
    end

    assign req_ready = grant;
    assign tanh_x    = any_grant ? req_x[grant_id*DW +: DW] : '0;
    assign busy      = |slot_busy;

    always_comb begin
        land = '0;
        for (int i = 0; i < N_REQ; i++) begin
            land[i] = tag_vld_p[LAT-1] && (tag_id_p[LAT-1] == IDW'(i));
        end
    end

    // Issue stage: grant decision and tag pipe entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            slot_busy <= '0;
            tag_vld_p <= '0;
            for (int s = 0; s < LAT; s++) tag_id_p[s] <= '0;
        end else begin
            if (any_grant) ptr <= ptr_nxt;
            slot_busy    <= (slot_busy & ~rsp_hs) | grant;
            tag_vld_p[0] <= any_grant;
            tag_id_p[0]  <= grant_id;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_p[s] <= tag_vld_p[s-1];
                tag_id_p[s]  <= tag_id_p[s-1];
            end
        end
    end

    // Return stage: capture unit result into the owner's result register
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_y     <= '0;
        end else begin
            rsp_valid <= (rsp_valid & ~rsp_hs) | land;
            for (int i = 0; i < N_REQ; i++) begin
                if (land[i]) rsp_y[i*DW +: DW] <= tanh_y;
            end
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
    a_grant_valid:  assert property (@(posedge clk) disable iff (!rst) (grant & ~req_valid) == '0);
    // A landing result must never overwrite one that is still held.
    a_no_clobber:   assert property (@(posedge clk) disable iff (!rst)
                                     (land & rsp_valid & ~rsp_hs) == '0);

endmodule

// File: tb/tb_tanh_share_arb.sv
// Randomized scoreboard bench for tanh_share_arb with a cycle-timed reference model
// and a behavioural tanhPWL unit attached to the shared port.
module tb_tanh_share_arb;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int LAT = 1;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_x;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N*DW-1:0] rsp_y;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   tanh_x;
    logic [DW-1:0]   tanh_y;
    logic            busy;

    tanh_share_arb #(.N_REQ(N), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
        .tanh_x(tanh_x), .tanh_y(tanh_y), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden tanhPWL on signed Q3.12: slopes 15/16, 7/16, 1/16, then saturate at 1.0.
    function automatic logic [DW-1:0] tanh_pwl(input logic [DW-1:0] x);
        int xs, a, y;
        xs = int'($signed(x));
        a  = (xs < 0) ? -xs : xs;
        if (a < 2048)       y = a - a / 16;
        else if (a < 6144)  y = 1920 + ((a - 2048) * 7) / 16;
        else if (a < 12288) y = 3712 + (a - 6144) / 16;
        else                y = 4096;
        if (xs < 0) y = -y;
        return DW'(y);
    endfunction

    // Shared unit model, LAT cycles deep, reset together with the arbiter.
    logic [DW-1:0] unit_p [LAT];
    always @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < LAT; s++) unit_p[s] <= '0;
        end else begin
            unit_p[0] <= tanh_pwl(tanh_x);
            for (int s = 1; s < LAT; s++) unit_p[s] <= unit_p[s-1];
        end
    end
    assign tanh_y = unit_p[LAT-1];

    typedef struct {
        int            lane;
        logic [DW-1:0] y;
        int            avail;
    } item_t;

    item_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            mptr = 0;
    bit            model_valid = 0;
    logic [DW-1:0] xv [N];

    function automatic int find_lane(input int lane);
        for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].lane == lane) return j;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference arbitration: search upward from the model pointer over lanes whose
    // slot is empty or whose held result is being taken this cycle.
    task automatic check_issue();
        logic [N-1:0] elig, exp_grant;
        int           k, j, idx;
        for (int i = 0; i < N; i++) begin
            idx     = find_lane(i);
            elig[i] = rst && req_valid[i] &&
                      (idx < 0 || (sb[idx].avail <= cyc && rsp_ready[i]));
        end
        k = -1;
        for (int off = 0; off < N; off++) begin
            j = (mptr + off) % N;
            if (k < 0 && elig[j]) k = j;
        end
        exp_grant = '0;
        if (k >= 0) exp_grant[k] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_grant));
        check("tanh_x", 64'(tanh_x), (k >= 0) ? 64'(xv[k]) : 64'd0);
        if (model_valid) check("busy", 64'(busy), 64'(sb.size() != 0));
        if (k >= 0) begin
            sb.push_back('{lane: k, y: tanh_pwl(xv[k]), avail: cyc + LAT + 1});
            mptr = (k + 1) % N;
        end
    endtask

    task automatic run_cycle(input logic r, input logic [N-1:0] v,
                             input logic [N-1:0] rr, input bit zero_x);
        @(posedge clk);
        if (!rst) begin
            sb.delete();
            mptr        = 0;
            model_valid = 1;
        end
        cyc++;
        #1;
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            xv[i]               = zero_x ? '0 : DW'($urandom);
            req_x[i*DW +: DW]   = xv[i];
        end
        @(negedge clk);
        check_issue();
    endtask

    // Response monitor: expected valid timing, held data, and pop on handshake.
    always begin
        @(negedge clk);
        #1;
        if (model_valid) begin
            for (int i = 0; i < N; i++) begin
                int  idx;
                bit  expv;
                idx  = find_lane(i);
                expv = (idx >= 0) && (sb[idx].avail <= cyc);
                check("rsp_valid", 64'(rsp_valid[i]), 64'(expv));
                if (expv) begin
                    check("rsp_y", 64'(rsp_y[i*DW +: DW]), 64'(sb[idx].y));
                    if (rsp_ready[i]) sb.delete(idx);
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_x     = '0;
        for (int i = 0; i < N; i++) xv[i] = '0;

        repeat (3) run_cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Single lane, zero operand
        run_cycle(1'b1, 4'b0001, 4'b1111, 1'b1);
        repeat (4) run_cycle(1'b1, 4'b0000, 4'b1111, 1'b1);

        // All lanes streaming, rotation 0,1,2,3 with wrap
        repeat (12) run_cycle(1'b1, 4'b1111, 4'b1111, 1'b0);
        repeat (3) run_cycle(1'b1, 4'b0000, 4'b1111, 1'b0);

        // Lane 2 back-pressured, others keep going, then release
        repeat (8) run_cycle(1'b1, 4'b1111, 4'b1011, 1'b0);
        repeat (4) run_cycle(1'b1, 4'b1111, 4'b1111, 1'b0);
        repeat (3) run_cycle(1'b1, 4'b0000, 4'b1111, 1'b0);

        // Move the pointer to 2, then lanes 1 and 3 compete
        run_cycle(1'b1, 4'b0010, 4'b1111, 1'b0);
        repeat (4) run_cycle(1'b1, 4'b1010, 4'b1111, 1'b0);
        repeat (3) run_cycle(1'b1, 4'b0000, 4'b1111, 1'b0);

        // Reset with work in flight, then lane 0 wins first
        repeat (2) run_cycle(1'b1, 4'b1111, 4'b0000, 1'b0);
        repeat (2) run_cycle(1'b0, 4'b1111, 4'b1111, 1'b0);
        repeat (4) run_cycle(1'b1, 4'b1111, 4'b1111, 1'b0);

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            run_cycle(($urandom_range(0, 59) != 0), N'($urandom), N'($urandom),
                      ($urandom_range(0, 7) == 0));
        end

        repeat (6) run_cycle(1'b1, 4'b0000, 4'b1111, 1'b0);
        check("drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
